alu_exec_unit: RTL and testbench
================================

Name: alu_exec_unit

Overview:
Parametrised successor to the ALU control decoder. Decodes aluop/funct into an operation, executes it, and returns a registered result over a valid/ready handshake. Single-cycle ops (add/sub/logic/slt) and iterative multi-cycle unsigned multiply/divide share one output register. Sits in the execute stage between the register-file operand latches and the writeback path.

Parameters:
WIDTH, 32, operand/result width in bits (>=4)
CNT_W, $clog2(WIDTH)+1, iteration counter width for mul/div

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous, active-low reset; sampled on rising edge of clk
aluop  in  3  main-control op class
funct  in  6  R-type function field, used only when aluop=3'b010
a  in  WIDTH  operand A
b  in  WIDTH  operand B
valid_in  in  1  request valid
ready_in  out  1  unit can accept a request this cycle
result  out  WIDTH  low result (sum/logic/product low/quotient)
result_hi  out  WIDTH  product high / remainder; 0 for single-cycle ops
valid_out  out  1  result valid
ready_out  in  1  consumer accepts result
illegal  out  1  qualified by valid_out: undecodable op
div_zero  out  1  qualified by valid_out: divide with b=0
busy  out  1  mul/div iteration in progress

Behaviour:
- Reset (rst_n=0 at edge): state=IDLE; valid_out, illegal, div_zero, busy=0; result, result_hi=0; counter=0. Reset mid-mul/div aborts it; no result is produced.
- Decode: aluop 000 ADD; 001 SUB; 011 AND; 100 OR; 101 SLT (signed); 010 uses funct: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 100110 XOR, 100111 NOR, 101010 SLT (signed), 101011 SLTU, 011001 MULTU, 011011 DIVU. Any other aluop/funct is ILLEGAL.
- Arithmetic: ADD/SUB wrap modulo 2^WIDTH; SLT/SLTU give result = {WIDTH-1 zeros, flag}.
- Accept: transfer when valid_in && ready_in. ready_in = (state==IDLE) && (!valid_out || ready_out).
- Single-cycle op or ILLEGAL: result registered on the accept edge. valid_out=1 next cycle (latency 1). ILLEGAL: result=0, result_hi=0, illegal=1. Throughput is 1/cycle under continuous ready_out.
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE -> MUL/DIV on accepted MULTU/DIVU. The accept edge loads operands and sets counter=WIDTH and busy=1.
  - MUL: one shift-add step per cycle. Counter decrements; at counter==1 go to DONE.
  - DIV: one restoring step per cycle. Same counter rule.
  - DONE: write result/result_hi, set valid_out=1, busy=0, go to IDLE.
  - Accept-to-valid_out latency is exactly WIDTH+1 cycles.
- MULTU: {result_hi,result} = a*b, full 2*WIDTH product.
- DIVU: result=a/b, result_hi=a%b. If b==0: still WIDTH+1 cycles; result=all ones, result_hi=a, div_zero=1.
- Output hold: while valid_out && !ready_out, result/result_hi/illegal/div_zero/valid_out are stable. valid_out clears on the ready_out edge unless a new single-cycle op is accepted the same cycle; in that case the new result replaces it and valid_out stays 1.
- ready_in is 0 in MUL, DIV and DONE. valid_in during those states is ignored and the request is not consumed. Operand inputs are don't-care when not accepted.
- illegal/div_zero are cleared when the corresponding result is consumed, unless replaced by a new result.
- No X on any output at any time after reset.

Test Plan:
- Reset then ADD: aluop=010 funct=100000 a=7 b=5, ready_out=1 -> next cycle valid_out=1, result=12, result_hi=0, illegal=0.
- Back-to-back: SUB a=3 b=5 (aluop=001), then SLT (funct 101010) a=-1 b=1, then SLTU a=-1 b=1 on consecutive cycles -> results 0xFFFFFFFE, 1, 0 on consecutive cycles; ready_in stays 1.
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> busy for 32 cycles, ready_in=0; valid_out at cycle 33 with result=0x00000001, result_hi=0xFFFFFFFE.
- DIVU a=100 b=7 -> result=14, result_hi=2 after 33 cycles. DIVU a=9 b=0 -> result=0xFFFFFFFF, result_hi=9, div_zero=1.
- Backpressure: ADD result held 5 cycles with ready_out=0 -> result stable, ready_in=0. Illegal funct 111111 -> result=0, illegal=1.
- Reset abort: rst_n=0 at cycle 10 of MULTU -> next cycle state IDLE, busy=0, valid_out=0, no result emitted afterwards.

Source files
------------

// File: rtl/alu_exec_unit_if.sv
// Request/response bundle between the operand latches, the execute unit and writeback.
// master = requester/consumer side, slave = alu_exec_unit.
interface alu_exec_unit_if #(
   parameter int unsigned WIDTH = 32
) ();
   logic [2:0]       aluop;
   logic [5:0]       funct;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             valid_in;
   logic             ready_in;
   logic [WIDTH-1:0] result;
   logic [WIDTH-1:0] result_hi;
   logic             valid_out;
   logic             ready_out;
   logic             illegal;
   logic             div_zero;
   logic             busy;

   modport master (
      output aluop, funct, a, b, valid_in, ready_out,
      input  ready_in, result, result_hi, valid_out, illegal, div_zero, busy
   );

   modport slave (
      input  aluop, funct, a, b, valid_in, ready_out,
      output ready_in, result, result_hi, valid_out, illegal, div_zero, busy
   );
endinterface

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: decodes aluop/funct, runs single-cycle ops or iterative unsigned
// multiply/divide, and returns a registered result over a valid/ready handshake.
module alu_exec_unit #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
   input logic            clk,
   input logic            rst_n,
   alu_exec_unit_if.slave bus
);

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StMul  = 2'd1;
   localparam logic [1:0] StDiv  = 2'd2;
   localparam logic [1:0] StDone = 2'd3;

   localparam logic [3:0] OpAdd  = 4'd0;
   localparam logic [3:0] OpSub  = 4'd1;
   localparam logic [3:0] OpAnd  = 4'd2;
   localparam logic [3:0] OpOr   = 4'd3;
   localparam logic [3:0] OpXor  = 4'd4;
   localparam logic [3:0] OpNor  = 4'd5;
   localparam logic [3:0] OpSlt  = 4'd6;
   localparam logic [3:0] OpSltu = 4'd7;
   localparam logic [3:0] OpMul  = 4'd8;
   localparam logic [3:0] OpDiv  = 4'd9;
   localparam logic [3:0] OpIll  = 4'd10;

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] mq_q, mq_d;
   logic [WIDTH-1:0] opb_q, opb_d;
   logic             op_div_q, op_div_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [WIDTH-1:0] result_hi_q, result_hi_d;
   logic             valid_q, valid_d;
   logic             illegal_q, illegal_d;
   logic             div_zero_q, div_zero_d;
   logic             busy_q, busy_d;

   logic [3:0]       op;
   logic [WIDTH-1:0] alu_res;
   logic             ready_in;
   logic             accept;
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   div_shift;
   logic [WIDTH-1:0] div_diff;
   logic             div_ge;
   logic [WIDTH-1:0] step_acc;
   logic [WIDTH-1:0] step_mq;

   always_comb begin
      op = OpIll;
      case (bus.aluop)
         3'b000: op = OpAdd;
         3'b001: op = OpSub;
         3'b011: op = OpAnd;
         3'b100: op = OpOr;
         3'b101: op = OpSlt;
         3'b010: begin
            case (bus.funct)
               6'b100000: op = OpAdd;
               6'b100010: op = OpSub;
               6'b100100: op = OpAnd;
               6'b100101: op = OpOr;
               6'b100110: op = OpXor;
               6'b100111: op = OpNor;
               6'b101010: op = OpSlt;
               6'b101011: op = OpSltu;
               6'b011001: op = OpMul;
               6'b011011: op = OpDiv;
               default:   op = OpIll;
            endcase
         end
         default: op = OpIll;
      endcase
   end

   always_comb begin
      alu_res = '0;
      case (op)
         OpAdd:   alu_res = bus.a + bus.b;
         OpSub:   alu_res = bus.a - bus.b;
         OpAnd:   alu_res = bus.a & bus.b;
         OpOr:    alu_res = bus.a | bus.b;
         OpXor:   alu_res = bus.a ^ bus.b;
         OpNor:   alu_res = ~(bus.a | bus.b);
         OpSlt:   alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
         OpSltu:  alu_res = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
         default: alu_res = '0;
      endcase
   end

   // One iteration step; the DONE edge applies the final step straight into the result.
   // With a zero divisor every step subtracts nothing, leaving quotient all-ones and
   // remainder equal to the dividend.
   always_comb begin
      mul_sum   = {1'b0, acc_q} + (mq_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
      div_shift = {acc_q, mq_q[WIDTH-1]};
      div_ge    = (div_shift >= {1'b0, opb_q});
      div_diff  = div_shift[WIDTH-1:0] - opb_q;
      if (op_div_q) begin
         step_acc = div_ge ? div_diff : div_shift[WIDTH-1:0];
         step_mq  = {mq_q[WIDTH-2:0], div_ge};
      end else begin
         step_acc = mul_sum[WIDTH:1];
         step_mq  = {mul_sum[0], mq_q[WIDTH-1:1]};
      end
   end

   assign ready_in = (state_q == StIdle) && (!valid_q || bus.ready_out);
   assign accept   = bus.valid_in && ready_in;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      acc_d       = acc_q;
      mq_d        = mq_q;
      opb_d       = opb_q;
      op_div_d    = op_div_q;
      result_d    = result_q;
      result_hi_d = result_hi_q;
      valid_d     = valid_q;
      illegal_d   = illegal_q;
      div_zero_d  = div_zero_q;
      busy_d      = busy_q;

      if (valid_q && bus.ready_out) begin
         valid_d    = 1'b0;
         illegal_d  = 1'b0;
         div_zero_d = 1'b0;
      end

      case (state_q)
         StIdle: begin
            if (accept) begin
               if (op == OpMul || op == OpDiv) begin
                  state_d  = (op == OpMul) ? StMul : StDiv;
                  op_div_d = (op == OpDiv);
                  cnt_d    = CNT_W'(WIDTH);
                  busy_d   = 1'b1;
                  acc_d    = '0;
                  mq_d     = bus.a;
                  opb_d    = bus.b;
               end else begin
                  result_d    = alu_res;
                  result_hi_d = '0;
                  illegal_d   = (op == OpIll);
                  div_zero_d  = 1'b0;
                  valid_d     = 1'b1;
               end
            end
         end
         StMul, StDiv: begin
            acc_d = step_acc;
            mq_d  = step_mq;
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_d == CNT_W'(1)) begin
               state_d = StDone;
            end
         end
         StDone: begin
            result_d    = step_mq;
            result_hi_d = step_acc;
            div_zero_d  = op_div_q && (opb_q == '0);
            illegal_d   = 1'b0;
            valid_d     = 1'b1;
            busy_d      = 1'b0;
            cnt_d       = '0;
            state_d     = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         acc_q       <= '0;
         mq_q        <= '0;
         opb_q       <= '0;
         op_div_q    <= 1'b0;
         result_q    <= '0;
         result_hi_q <= '0;
         valid_q     <= 1'b0;
         illegal_q   <= 1'b0;
         div_zero_q  <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         acc_q       <= acc_d;
         mq_q        <= mq_d;
         opb_q       <= opb_d;
         op_div_q    <= op_div_d;
         result_q    <= result_d;
         result_hi_q <= result_hi_d;
         valid_q     <= valid_d;
         illegal_q   <= illegal_d;
         div_zero_q  <= div_zero_d;
         busy_q      <= busy_d;
      end
   end

   assign bus.ready_in  = ready_in;
   assign bus.result    = result_q;
   assign bus.result_hi = result_hi_q;
   assign bus.valid_out = valid_q;
   assign bus.illegal   = illegal_q;
   assign bus.div_zero  = div_zero_q;
   assign bus.busy      = busy_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed plus randomized bench for alu_exec_unit, checked against an arithmetic
// reference model of the decode/execute rules.
module tb_alu_exec_unit;
   localparam int unsigned W = 32;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_cmp = 0;
   int   n_fail = 0;

   alu_exec_unit_if #(.WIDTH(W)) bus ();

   alu_exec_unit #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: observed no finish, expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

   typedef enum {KAdd, KSub, KAnd, KOr, KXor, KNor, KSlt, KSltu, KMul, KDiv, KIll} kind_e;

   typedef struct packed {
      logic [W-1:0] res;
      logic [W-1:0] hi;
      logic         ill;
      logic         dz;
      logic         multi;
   } exp_t;

   function automatic exp_t model(input logic [2:0] op, input logic [5:0] f,
                                  input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t           e;
      kind_e          k;
      logic [2*W-1:0] prod;
      e = '0;
      k = KIll;
      case (op)
         3'b000: k = KAdd;
         3'b001: k = KSub;
         3'b011: k = KAnd;
         3'b100: k = KOr;
         3'b101: k = KSlt;
         3'b010: begin
            case (f)
               6'h20:   k = KAdd;
               6'h22:   k = KSub;
               6'h24:   k = KAnd;
               6'h25:   k = KOr;
               6'h26:   k = KXor;
               6'h27:   k = KNor;
               6'h2A:   k = KSlt;
               6'h2B:   k = KSltu;
               6'h19:   k = KMul;
               6'h1B:   k = KDiv;
               default: k = KIll;
            endcase
         end
         default: k = KIll;
      endcase
      case (k)
         KAdd: e.res = a + b;
         KSub: e.res = a - b;
         KAnd: e.res = a & b;
         KOr:  e.res = a | b;
         KXor: e.res = a ^ b;
         KNor: e.res = ~(a | b);
         KSlt: e.res = ($signed(a) < $signed(b)) ? 1 : 0;
         KSltu: e.res = (a < b) ? 1 : 0;
         KMul: begin
            prod    = {{W{1'b0}}, a} * {{W{1'b0}}, b};
            e.res   = prod[W-1:0];
            e.hi    = prod[2*W-1:W];
            e.multi = 1'b1;
         end
         KDiv: begin
            e.multi = 1'b1;
            if (b == 0) begin
               e.res = '1;
               e.hi  = a;
               e.dz  = 1'b1;
            end else begin
               e.res = a / b;
               e.hi  = a % b;
            end
         end
         default: e.ill = 1'b1;
      endcase
      return e;
   endfunction

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_bit(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [2:0] op, input logic [5:0] f,
                        input logic [W-1:0] a, input logic [W-1:0] b);
      bus.aluop    = op;
      bus.funct    = f;
      bus.a        = a;
      bus.b        = b;
      bus.valid_in = 1'b1;
   endtask

   task automatic pick_single(output logic [2:0] op, output logic [5:0] f);
      op = 3'($urandom_range(0, 7));
      f  = 6'($urandom);
      if (op == 3'b010) begin
         case ($urandom_range(0, 8))
            0: f = 6'h20;
            1: f = 6'h22;
            2: f = 6'h24;
            3: f = 6'h25;
            4: f = 6'h26;
            5: f = 6'h27;
            6: f = 6'h2A;
            7: f = 6'h2B;
            default: if (f == 6'h19 || f == 6'h1B) f = 6'h3F;
         endcase
      end
   endtask

   // Entered at a negedge with the unit idle; leaves at a negedge after the result is consumed.
   task automatic run_op(input logic [2:0] op, input logic [5:0] f, input logic [W-1:0] a,
                         input logic [W-1:0] b, input bit poke);
      exp_t e;
      int   lat;
      int   busy_cnt;
      e = model(op, f, a, b);
      drive(op, f, a, b);
      bus.ready_out = 1'b1;
      #1 check_bit("ready_in_idle", bus.ready_in, 1'b1);
      @(negedge clk);
      // Optionally keep a request pending while iterating; it must not be taken.
      if (poke && e.multi) drive(3'b000, 6'h00, a ^ 1, b);
      else bus.valid_in = 1'b0;
      lat = 1;
      busy_cnt = 0;
      while (bus.valid_out !== 1'b1 && lat < int'(W) + 8) begin
         if (bus.busy === 1'b1) busy_cnt++;
         check_bit("ready_in_busy", bus.ready_in, 1'b0);
         @(negedge clk);
         lat++;
      end
      bus.valid_in = 1'b0;
      check("latency", lat, e.multi ? W + 1 : 1);
      if (e.multi) check("busy_cycles", busy_cnt, W);
      check_bit("busy_at_valid", bus.busy, 1'b0);
      check("result", bus.result, e.res);
      check("result_hi", bus.result_hi, e.hi);
      check_bit("illegal", bus.illegal, e.ill);
      check_bit("div_zero", bus.div_zero, e.dz);
      @(negedge clk);
      check_bit("consumed", bus.valid_out, 1'b0);
      check_bit("flags_cleared", bus.illegal | bus.div_zero, 1'b0);
   endtask

   initial begin
      exp_t         q[$];
      exp_t         e;
      logic [2:0]   op;
      logic [5:0]   f;
      logic [W-1:0] a;
      logic [W-1:0] b;
      int           vcnt;

      bus.aluop     = '0;
      bus.funct     = '0;
      bus.a         = '0;
      bus.b         = '0;
      bus.valid_in  = 1'b0;
      bus.ready_out = 1'b0;
      rst_n         = 1'b0;
      repeat (3) @(negedge clk);
      check_bit("rst_valid_out", bus.valid_out, 1'b0);
      check("rst_result", bus.result, '0);
      check("rst_result_hi", bus.result_hi, '0);
      check_bit("rst_illegal", bus.illegal, 1'b0);
      check_bit("rst_div_zero", bus.div_zero, 1'b0);
      check_bit("rst_busy", bus.busy, 1'b0);
      check_bit("rst_ready_in", bus.ready_in, 1'b1);
      rst_n = 1'b1;
      @(negedge clk);

      run_op(3'b010, 6'h20, 7, 5, 1'b0);

      // Back-to-back single-cycle ops at full throughput.
      bus.ready_out = 1'b1;
      for (int i = 0; i <= 15; i++) begin
         if (i > 0) begin
            e = q.pop_front();
            check_bit("b2b_valid", bus.valid_out, 1'b1);
            check("b2b_result", bus.result, e.res);
            check("b2b_result_hi", bus.result_hi, e.hi);
            check_bit("b2b_illegal", bus.illegal, e.ill);
         end
         if (i < 15) begin
            case (i)
               0: begin op = 3'b001; f = 6'h00; a = 3;   b = 5; end
               1: begin op = 3'b010; f = 6'h2A; a = '1;  b = 1; end
               2: begin op = 3'b010; f = 6'h2B; a = '1;  b = 1; end
               default: begin
                  pick_single(op, f);
                  a = $urandom;
                  b = $urandom;
               end
            endcase
            drive(op, f, a, b);
            q.push_back(model(op, f, a, b));
            #1 check_bit("b2b_ready_in", bus.ready_in, 1'b1);
         end else begin
            bus.valid_in = 1'b0;
         end
         @(negedge clk);
      end
      check_bit("b2b_drained", bus.valid_out, 1'b0);

      run_op(3'b010, 6'h19, '1, '1, 1'b1);
      run_op(3'b010, 6'h1B, 100, 7, 1'b1);
      run_op(3'b010, 6'h1B, 9, 0, 1'b0);
      run_op(3'b010, 6'h3F, 11, 22, 1'b0);
      run_op(3'b110, 6'h20, 11, 22, 1'b0);

      for (int i = 0; i < 6; i++) begin
         a = $urandom;
         b = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 15)) : W'($urandom);
         run_op(3'b010, (i % 2 == 0) ? 6'h19 : 6'h1B, a, b, 1'b1);
      end
      for (int i = 0; i < 10; i++) begin
         pick_single(op, f);
         run_op(op, f, $urandom, $urandom, 1'b0);
      end

      // Backpressure: result held while a second request waits, then replaced on release.
      bus.ready_out = 1'b0;
      drive(3'b000, 6'h00, 40, 2);
      @(negedge clk);
      drive(3'b001, 6'h00, 50, 9);
      for (int k = 0; k < 5; k++) begin
         check_bit("hold_valid", bus.valid_out, 1'b1);
         check("hold_result", bus.result, 42);
         check_bit("hold_ready_in", bus.ready_in, 1'b0);
         @(negedge clk);
      end
      bus.ready_out = 1'b1;
      #1 check_bit("release_ready_in", bus.ready_in, 1'b1);
      @(negedge clk);
      bus.valid_in = 1'b0;
      check_bit("replace_valid", bus.valid_out, 1'b1);
      check("replace_result", bus.result, 41);
      @(negedge clk);
      check_bit("replace_consumed", bus.valid_out, 1'b0);

      // Reset during a multiply aborts it with no result.
      drive(3'b010, 6'h19, $urandom, $urandom);
      @(negedge clk);
      bus.valid_in = 1'b0;
      repeat (9) @(negedge clk);
      check_bit("abort_busy_before", bus.busy, 1'b1);
      rst_n = 1'b0;
      @(negedge clk);
      check_bit("abort_busy", bus.busy, 1'b0);
      check_bit("abort_valid", bus.valid_out, 1'b0);
      check("abort_result", bus.result, '0);
      check_bit("abort_ready_in", bus.ready_in, 1'b1);
      rst_n = 1'b1;
      vcnt = 0;
      repeat (W + 5) begin
         @(negedge clk);
         if (bus.valid_out === 1'b1) vcnt++;
      end
      check("abort_no_result", vcnt, 0);
      run_op(3'b000, 6'h00, 123, 877, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
